add_sub: RTL and testbench

- Registered sign-magnitude adder/subtractor for small signed operands.
- Takes two (MAG_W+1)-bit sign-magnitude numbers and adds or subtracts them under a select bit.
- Produces a sign-magnitude result plus a zero flag.
- Sits in the arithmetic datapath, feeding display/status logic that consumes sign-magnitude values directly.

---
 rtl/add_sub.sv | 62 ++++++
 tb/tb_add_sub.sv | 138 +++++++++++++
 2 files changed

// File: rtl/add_sub.sv
// Registered sign-magnitude adder/subtractor: decodes two sign-magnitude operands,
// adds or subtracts them exactly, and registers a sign-magnitude result plus zero flag.
module add_sub #(
  parameter int MAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W:0]   num1,
  input  logic [MAG_W:0]   num2,
  input  logic             selection,
  output logic [MAG_W+2:0] result,
  output logic             zeroflag
);

  localparam int SUM_W = MAG_W + 3;

  // Negative zero decodes to 0 because negating a zero magnitude is still zero.
  function automatic logic signed [SUM_W-1:0] sm_decode(input logic [MAG_W:0] x);
    logic signed [SUM_W-1:0] mag;
    mag = $signed({{(SUM_W-MAG_W){1'b0}}, x[MAG_W-1:0]});
    return x[MAG_W] ? -mag : mag;
  endfunction

  // The sign bit is set only for strictly negative values, so zero is always +0.
  function automatic logic [SUM_W-1:0] sm_encode(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] absv;
    logic                    neg;
    neg  = (v < 0);
    absv = neg ? -v : v;
    return {neg, absv[SUM_W-2:0]};
  endfunction

  logic signed [SUM_W-1:0] a_p0;
  logic signed [SUM_W-1:0] b_p0;
  logic signed [SUM_W-1:0] sum_p0;
  logic        [SUM_W-1:0] enc_p0;
  logic        [SUM_W-1:0] result_p1;
  logic                    zeroflag_p1;

  // Stage p0: decode, compute and encode in full-width two's complement.
  always_comb begin
    a_p0   = sm_decode(num1);
    b_p0   = sm_decode(num2);
    sum_p0 = selection ? (a_p0 - b_p0) : (a_p0 + b_p0);
    enc_p0 = sm_encode(sum_p0);
  end

  // Stage p1: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1   <= '0;
      zeroflag_p1 <= 1'b1;
    end else begin
      result_p1   <= enc_p0;
      zeroflag_p1 <= (enc_p0[SUM_W-2:0] == '0);
    end
  end

  assign result   = result_p1;
  assign zeroflag = zeroflag_p1;

endmodule

// File: tb/tb_add_sub.sv
// Randomized and directed bench for add_sub against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_add_sub;

  localparam int MAG_W = 2;
  localparam int RES_W = MAG_W + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [MAG_W:0]   num1;
  logic [MAG_W:0]   num2;
  logic             selection;
  logic [RES_W-1:0] result;
  logic             zeroflag;

  int checks = 0;
  int errors = 0;

  add_sub #(.MAG_W(MAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .num1(num1), .num2(num2),
    .selection(selection), .result(result), .zeroflag(zeroflag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input int code);
    int mag;
    mag = code & ((1 << MAG_W) - 1);
    return ((code >> MAG_W) & 1) ? -mag : mag;
  endfunction

  function automatic int model(input int n1, input int n2, input int sel);
    int r;
    r = sel ? decode(n1) - decode(n2) : decode(n1) + decode(n2);
    return (r < 0) ? ((1 << (RES_W - 1)) | -r) : r;
  endfunction

  function automatic int model_zero(input int n1, input int n2, input int sel);
    return ((model(n1, n2, sel) & ((1 << (RES_W - 1)) - 1)) == 0) ? 1 : 0;
  endfunction

  task automatic apply(input string tag, input int n1, input int n2, input int sel);
    @(negedge clk);
    num1 = n1[MAG_W:0];
    num2 = n2[MAG_W:0];
    selection = sel[0];
    @(posedge clk);
    #1;
    check({tag, ".result"}, 32'(result), 32'(model(n1, n2, sel)));
    check({tag, ".zero"}, 32'(zeroflag), 32'(model_zero(n1, n2, sel)));
  endtask

  // Directed vectors with hand-derived expected results: {num1, num2, sel, result}
  int dir_tbl [8][4] = '{
    '{3'b011, 3'b011, 0, 5'b00110},
    '{3'b101, 3'b011, 0, 5'b00010},
    '{3'b111, 3'b011, 1, 5'b10110},
    '{3'b001, 3'b111, 1, 5'b00100},
    '{3'b100, 3'b000, 0, 5'b00000},
    '{3'b010, 3'b010, 1, 5'b00000},
    '{3'b110, 3'b010, 0, 5'b00000},
    '{3'b100, 3'b100, 1, 5'b00000}
  };

  initial begin
    rst_n = 1'b1;
    num1 = 3'b011;
    num2 = 3'b011;
    selection = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("preload", 32'(result), 32'h06);

    // Asynchronous assertion mid-cycle with non-zero inputs.
    #2 rst_n = 1'b0;
    #1;
    check("rst.async.result", 32'(result), 32'h0);
    check("rst.async.zero", 32'(zeroflag), 32'h1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst.hold.result", 32'(result), 32'h0);
      check("rst.hold.zero", 32'(zeroflag), 32'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.release.result", 32'(result), 32'h0);
    @(posedge clk);
    #1;
    check("rst.firstload", 32'(result), 32'h06);

    for (int i = 0; i < 8; i++) begin
      apply("directed", dir_tbl[i][0], dir_tbl[i][1], dir_tbl[i][2]);
      check("directed.const", 32'(result), 32'(dir_tbl[i][3]));
      check("directed.constzero", 32'(zeroflag), 32'(dir_tbl[i][3] == 0));
    end

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          apply("sweep", a, b, s);

    for (int i = 0; i < 200; i++)
      apply("random", int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(1)));

    // Input changes between edges must not reach the outputs.
    apply("stable.base", 3'b011, 3'b111, 1);
    num1 = 3'b000;
    num2 = 3'b000;
    selection = 1'b0;
    #3;
    check("stable.result", 32'(result), 32'(model(3'b011, 3'b111, 1)));
    check("stable.zero", 32'(zeroflag), 32'h0);
    @(posedge clk);
    #1;
    check("stable.next", 32'(result), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
